// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational ALU with a one-entry response register.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority to requester 0 with a starvation guard for requester 1.
module alu_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic        req1_valid,
    output logic        req0_ready,
    output logic        req1_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [3:0]  req0_sel,
    input  logic [3:0]  req1_sel,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_sel,
    input  logic [31:0] alu_out,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_id
);

    // The starvation counter is three bits wide, so the limit must fit in it.
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 7) begin : g_bad_limit
        $error("alu_arbiter: STARVE_LIMIT must be in 1..7");
    end

    logic        w_slot_free;
    logic        w_pick1;
    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_hs;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_data;
    logic        r_rsp_id;
    logic        r_last_grant;

    assign w_slot_free = !r_rsp_valid || rsp_ready;

`ifdef ALU_ARB_FIXED_PRIO_EN
    logic [2:0] r_starve;

    assign w_pick1 = (r_starve == 3'(STARVE_LIMIT));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve <= '0;
        end else if (!req1_valid || w_gnt1) begin
            r_starve <= '0;
        end else if (w_slot_free && w_gnt0 && r_starve != 3'(STARVE_LIMIT)) begin
            r_starve <= r_starve + 3'd1;
        end
    end
`else
    assign w_pick1 = !r_last_grant;
`endif

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!rst && w_slot_free) begin
            if (req0_valid && req1_valid) begin
                w_gnt1 = w_pick1;
                w_gnt0 = !w_pick1;
            end else begin
                w_gnt0 = req0_valid;
                w_gnt1 = req1_valid;
            end
        end
    end

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;
    assign w_hs       = w_gnt0 || w_gnt1;

    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_sel = '0;
        if (w_gnt0) begin
            alu_a   = req0_a;
            alu_b   = req0_b;
            alu_sel = req0_sel;
        end else if (w_gnt1) begin
            alu_a   = req1_a;
            alu_b   = req1_b;
            alu_sel = req1_sel;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_id     <= 1'b0;
            r_last_grant <= 1'b1;
        end else if (w_hs) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_data   <= alu_out;
            r_rsp_id     <= w_gnt1;
            r_last_grant <= w_gnt1;
        end else if (rsp_ready) begin
            r_rsp_valid  <= 1'b0;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_id    = r_rsp_id;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: bench-side shared ALU, response scoreboard and per-scenario tasks.
// Build with ALU_ARB_FIXED_PRIO_EN defined to exercise the fixed-priority variant.
module tb_alu_arbiter;

    localparam int STARVE_LIMIT = 4;

    typedef struct packed {
        logic        id;
        logic [31:0] data;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_sel, req1_sel;
    logic [31:0] alu_a, alu_b, alu_out;
    logic [3:0]  alu_sel;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_data;

    int checks = 0;
    int errors = 0;

    rsp_t        sb_q[$];
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_id;
    logic        m_last;
    int          m_starve;

    always #5 clk = ~clk;

    alu_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_sel(req0_sel), .req1_sel(req1_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id)
    );

    function automatic logic [31:0] alu_model(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
        case (sel)
            4'h0: return a + b;
            4'h1: return a - b;
            4'h2: return a & b;
            4'h3: return a | b;
            4'h4: return a ^ b;
            4'h5: return ~a;
            4'h6: return a << b[4:0];
            4'h7: return a >> b[4:0];
            4'h8: return {31'd0, $signed(a) < $signed(b)};
            4'h9: return {31'd0, a < b};
            4'hE: return b;
            4'hF: return a;
            default: return 32'd0;
        endcase
    endfunction

    // Bench-owned shared ALU fed by the DUT's routed operands.
    assign alu_out = alu_model(alu_sel, alu_a, alu_b);

    task automatic rand_ops();
        req0_a   = $urandom;
        req0_b   = $urandom;
        req1_a   = $urandom;
        req1_b   = $urandom;
        req0_sel = 4'($urandom_range(0, 15));
        req1_sel = 4'($urandom_range(0, 15));
    endtask

    // One clock: check readies/ALU routing against the arbitration model, push the expected
    // result on a handshake, then pop and compare once the response register loads.
    task automatic step(output logic o_hs, output logic o_id);
        logic free, w1, e0, e1, rr;
        rsp_t exp;
        @(negedge clk);
        #1;
        rr   = rsp_ready;
        free = !rst && (!m_valid || rr);
`ifdef ALU_ARB_FIXED_PRIO_EN
        w1 = (m_starve == STARVE_LIMIT);
`else
        w1 = !m_last;
`endif
        e1 = free && req1_valid && (!req0_valid || w1);
        e0 = free && req0_valid && !e1;
        checks++;
        if ({req0_ready, req1_ready} !== {e0, e1}) begin
            errors++;
            $display("FAIL ready: got r0=%b r1=%b expected r0=%b r1=%b", req0_ready, req1_ready, e0, e1);
        end
        if (e0 || e1) begin
            exp.id   = e1;
            exp.data = e1 ? alu_model(req1_sel, req1_a, req1_b) : alu_model(req0_sel, req0_a, req0_b);
            sb_q.push_back(exp);
        end else begin
            checks++;
            if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_sel !== 4'd0) begin
                errors++;
                $display("FAIL alu_idle: got a=%h b=%h sel=%h expected zeros", alu_a, alu_b, alu_sel);
            end
        end
        o_hs = e0 || e1;
        o_id = e1;
        @(posedge clk);
        #1;
        if (rst) begin
            m_valid  = 1'b0;
            m_data   = 32'd0;
            m_id     = 1'b0;
            m_last   = 1'b1;
            m_starve = 0;
            sb_q.delete();
        end else begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            if (!req1_valid || e1) m_starve = 0;
            else if (free && e0 && m_starve < STARVE_LIMIT) m_starve++;
`endif
            if (e0 || e1) begin
                exp     = sb_q.pop_front();
                m_valid = 1'b1;
                m_data  = exp.data;
                m_id    = exp.id;
                m_last  = exp.id;
            end else if (rr) begin
                m_valid = 1'b0;
            end
        end
        checks++;
        if (rsp_valid !== m_valid) begin
            errors++;
            $display("FAIL rsp_valid: got %b expected %b", rsp_valid, m_valid);
        end
        checks++;
        if (rsp_data !== m_data || rsp_id !== m_id) begin
            errors++;
            $display("FAIL rsp: got data=%h id=%b expected data=%h id=%b", rsp_data, rsp_id, m_data, m_id);
        end
    endtask

    task automatic test_reset();
        logic hs, id;
        rst = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        rsp_ready  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_ops();
            step(hs, id);
        end
        checks++;
        if (rsp_valid !== 1'b0 || rsp_data !== 32'd0 || rsp_id !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got v=%b d=%h id=%b expected 0/0/0", rsp_valid, rsp_data, rsp_id);
        end
        rst = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step(hs, id);
    endtask

    task automatic test_single_op();
        logic hs, id;
        req0_valid = 1'b1;
        req0_a     = 32'd5;
        req0_b     = 32'd3;
        req0_sel   = 4'b0001;
        rsp_ready  = 1'b1;
        step(hs, id);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'd2 || rsp_id !== 1'b0) begin
            errors++;
            $display("FAIL single_op: got v=%b d=%h id=%b expected 1/00000002/0", rsp_valid, rsp_data, rsp_id);
        end
        req0_valid = 1'b0;
        step(hs, id);
        checks++;
        if (rsp_valid !== 1'b0 || rsp_data !== 32'd2) begin
            errors++;
            $display("FAIL drain_hold: got v=%b d=%h expected 0/00000002", rsp_valid, rsp_data);
        end
    endtask

    task automatic test_contention();
        logic       hs, id;
        logic [0:9] seq;
`ifdef ALU_ARB_FIXED_PRIO_EN
        seq = 10'b0000100001;
`else
        seq = 10'b0101010101;
`endif
        rst = 1'b1;
        step(hs, id);
        rst = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        rsp_ready  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rand_ops();
            step(hs, id);
            checks++;
            if (hs !== 1'b1 || rsp_id !== seq[i] || rsp_valid !== 1'b1) begin
                errors++;
                $display("FAIL contention[%0d]: got hs=%b id=%b v=%b expected hs=1 id=%b v=1", i, hs, rsp_id, rsp_valid, seq[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic        hs, id;
        logic [31:0] d;
        logic        di;
        d  = rsp_data;
        di = rsp_id;
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_ops();
            step(hs, id);
            checks++;
            if (hs !== 1'b0 || rsp_valid !== 1'b1 || rsp_data !== d || rsp_id !== di) begin
                errors++;
                $display("FAIL backpressure[%0d]: got hs=%b v=%b d=%h id=%b expected 0/1/%h/%b", i, hs, rsp_valid, rsp_data, rsp_id, d, di);
            end
        end
        rand_ops();
        rsp_ready = 1'b1;
        step(hs, id);
        checks++;
        if (hs !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: got hs=%b expected 1", hs);
        end
    endtask

    task automatic test_pass_through();
        logic hs, id;
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        rsp_ready  = 1'b1;
        req1_a     = $urandom;
        req1_b     = 32'hDEADBEEF;
        req1_sel   = 4'b1110;
        step(hs, id);
        checks++;
        if (rsp_data !== 32'hDEADBEEF || rsp_id !== 1'b1) begin
            errors++;
            $display("FAIL pass_b: got d=%h id=%b expected deadbeef/1", rsp_data, rsp_id);
        end
        for (int s = 10; s <= 13; s++) begin
            req1_a   = $urandom;
            req1_b   = $urandom | 32'h1;
            req1_sel = 4'(s);
            step(hs, id);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== 32'd0 || rsp_id !== 1'b1) begin
                errors++;
                $display("FAIL unused_op %0d: got v=%b d=%h id=%b expected 1/00000000/1", s, rsp_valid, rsp_data, rsp_id);
            end
        end
        req1_valid = 1'b0;
        step(hs, id);
    endtask

    task automatic test_reset_mid_op();
        logic hs, id;
        req0_valid = 1'b1;
        req1_valid = 1'b0;
        rsp_ready  = 1'b0;
        rand_ops();
        step(hs, id);
        rst = 1'b1;
        req0_valid = 1'b0;
        step(hs, id);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_op: got v=%b expected 0", rsp_valid);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(hs, id);
            checks++;
            if (rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_idle[%0d]: got v=%b expected 0", i, rsp_valid);
            end
        end
    endtask

    task automatic test_random();
        logic hs, id;
        for (int i = 0; i < 300; i++) begin
            rand_ops();
            req0_valid = 1'($urandom_range(0, 1));
            req1_valid = 1'($urandom_range(0, 1));
            rsp_ready  = ($urandom_range(0, 3) != 0);
            step(hs, id);
        end
    endtask

    initial begin
        rst        = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b0;
        rand_ops();
        m_valid  = 1'b0;
        m_data   = 32'd0;
        m_id     = 1'b0;
        m_last   = 1'b1;
        m_starve = 0;
        test_reset();
        test_single_op();
        test_contention();
        test_backpressure();
        test_pass_through();
        test_reset_mid_op();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
